// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM state type, NOP encoding and branch opcodes.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [5:0]  OPC_BEQ  = 6'b000100;
    localparam logic [5:0]  OPC_BNE  = 6'b000101;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset, load enable and clear; clear beats enable.
module pipe_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            data_q <= CLR_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF stage control: PC register, next-PC mux, IF/ID register, stall/flush FSM and stall watchdog.
// Optional stall performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PCWrite,
    input  logic         IFIDWrite,
    input  logic         hazard,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         jump,
    input  logic [31:0]  jump_target,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  imem_addr,
    output logic [31:0]  ifid_inst,
    output logic [31:0]  ifid_pc4,
    output logic         ifid_valid,
    output logic         ctrl_err,
    output logic         stall_timeout,
    output logic [31:0]  stall_cycles,
    output fetch_state_t fetch_state
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    logic [31:0]      pc_q, pc_d, pc_plus4;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             ctrl_err_q;
    fetch_state_t     state_q, state_d;
    logic             redirect, stall, advance;

    // Redirect outranks stall: a resolved branch while PCWrite=0 still redirects.
    assign redirect = (branch_taken | jump) & ~hazard;
    assign stall    = ~redirect & (~PCWrite | ~IFIDWrite);
    assign advance  = ~redirect & ~stall;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d        = pc_plus4;
        state_d     = RUN;
        stall_cnt_d = '0;
        if (redirect) begin
            pc_d    = branch_taken ? branch_target : jump_target;
            state_d = FLUSH;
        end else if (stall) begin
            pc_d        = pc_q;
            state_d     = STALL;
            stall_cnt_d = (stall_cnt_q == MAX_CNT) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            state_q     <= RUN;
            stall_cnt_q <= '0;
            ctrl_err_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            ctrl_err_q  <= PCWrite ^ IFIDWrite;
        end
    end

    pipe_reg #(.WIDTH(32), .CLR_VAL(NOP_INST)) u_ifid_inst (
        .clk(clk), .rst(rst), .en_i(advance), .clr_i(redirect),
        .d_i(imem_rdata), .q_o(ifid_inst)
    );

    pipe_reg #(.WIDTH(32)) u_ifid_pc4 (
        .clk(clk), .rst(rst), .en_i(advance), .clr_i(redirect),
        .d_i(pc_plus4), .q_o(ifid_pc4)
    );

    pipe_reg #(.WIDTH(1)) u_ifid_valid (
        .clk(clk), .rst(rst), .en_i(advance), .clr_i(redirect),
        .d_i(1'b1), .q_o(ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = 32'h0;
`endif

    assign imem_addr     = pc_q;
    assign ctrl_err      = ctrl_err_q;
    assign stall_timeout = (stall_cnt_q == MAX_CNT);
    assign fetch_state   = state_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: directed scenarios followed by random control traffic.
module tb_fetch_stage_ctrl;
    import pipe_pkg::*;

    localparam int unsigned MAX_STALL = 8;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic         clk;
    logic         rst;
    logic         PCWrite, IFIDWrite, hazard, branch_taken, jump;
    logic [31:0]  branch_target, jump_target;
    logic [31:0]  imem_rdata, imem_addr, ifid_inst, ifid_pc4, stall_cycles;
    logic         ifid_valid, ctrl_err, stall_timeout;
    fetch_state_t fetch_state;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic        tmo;
        logic [31:0] perf;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_pc4, m_perf;
    logic        m_valid, m_err;
    int          m_run;
    logic [1:0]  m_st;

    fetch_stage_ctrl #(.RESET_PC(RESET_PC), .MAX_STALL(MAX_STALL), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .hazard(hazard),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
        .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .ctrl_err(ctrl_err), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles),
        .fetch_state(fetch_state)
    );

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    assign imem_rdata = imem_fn(imem_addr);

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; hazard = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;
    end

    // Model: one clock edge of the fetch stage, written from the behavioural rules.
    task automatic model_step(input logic r, pcw, ifw, hz, bt, input logic [31:0] bta,
                              input logic j, input logic [31:0] jta);
        exp_t e;
        if (r) begin
            m_pc = RESET_PC; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_err = 1'b0; m_run = 0; m_perf = 32'h0; m_st = 2'd0;
        end else begin
            m_err = (pcw != ifw);
            if ((bt || j) && !hz) begin
                m_pc = bt ? bta : jta;
                m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                m_run = 0; m_st = 2'd2;
            end else if (!pcw || !ifw) begin
                m_run = (m_run >= MAX_STALL) ? MAX_STALL : m_run + 1;
                m_perf = m_perf + 1;
                m_st = 2'd1;
            end else begin
                m_inst = imem_fn(m_pc);
                m_pc4 = m_pc + 4;
                m_pc = m_pc + 4;
                m_valid = 1'b1; m_run = 0; m_st = 2'd0;
            end
        end
        e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.err = m_err;
        e.tmo = (m_run == MAX_STALL);
`ifdef FETCH_PERF_CNT_EN
        e.perf = m_perf;
`else
        e.perf = 32'h0;
`endif
        e.st = m_st;
        exp_q.push_back(e);
    endtask

    // driver
    task automatic drive(input logic r, pcw, ifw, hz, bt, input logic [31:0] bta,
                         input logic j, input logic [31:0] jta);
        @(negedge clk);
        #1;
        rst = r; PCWrite = pcw; IFIDWrite = ifw; hazard = hz;
        branch_taken = bt; branch_target = bta; jump = j; jump_target = jta;
        model_step(r, pcw, ifw, hz, bt, bta, j, jta);
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic stl(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_addr", imem_addr, e.pc);
                check("ifid_inst", ifid_inst, e.inst);
                check("ifid_pc4", ifid_pc4, e.pc4);
                check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
                check("ctrl_err", {31'b0, ctrl_err}, {31'b0, e.err});
                check("stall_timeout", {31'b0, stall_timeout}, {31'b0, e.tmo});
                check("stall_cycles", stall_cycles, e.perf);
                check("fetch_state", {30'b0, fetch_state}, {30'b0, e.st});
            end
        end
    end

    // stimulus
    initial begin
        logic [31:0] t1, t2;
        logic        pcw, ifw;
        int          wait_cnt;

        drive(1, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        adv(3);                                     // PC 0 -> 4 -> 8 -> 12
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        adv(2);                                     // PC at 8
        stl(2);
        adv(1);                                     // resumes to 12
        drive(0, 1, 1, 0, 1, 32'h40, 0, 0);         // taken branch -> 0x40
        adv(1);
        drive(0, 0, 0, 1, 1, 32'h80, 0, 0);         // hazard masks the branch
        drive(0, 1, 1, 1, 0, 0, 1, 32'h100);        // hazard masks the jump
        drive(0, 1, 1, 0, 1, 32'h200, 1, 32'h300);  // branch wins over jump
        stl(MAX_STALL + 2);                         // watchdog saturates
        adv(1);
        drive(0, 1, 0, 0, 0, 0, 0, 0);              // illegal split stall
        adv(2);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        stl(3);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h500);        // redirect during stall
        stl(4);
        drive(1, 0, 0, 0, 0, 0, 0, 0);              // reset mid-stall
        drive(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        adv(2);                                     // PC wraps
        drive(0, 1, 1, 0, 1, 32'h20, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);              // reset mid-flush
        adv(1);

        for (int i = 0; i < 400; i++) begin
            t1 = $urandom() & 32'hFFFF_FFFC;
            t2 = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) t1 = 32'hFFFF_FFF8;
            pcw = ($urandom_range(0, 3) != 0);
            ifw = ($urandom_range(0, 7) == 0) ? ~pcw : pcw;
            if ($urandom_range(0, 19) == 0 && i > 0) begin
                stl($urandom_range(MAX_STALL - 1, MAX_STALL + 3));
            end
            drive(($urandom_range(0, 49) == 0), pcw, ifw, ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 6) == 0), t1, ($urandom_range(0, 9) == 0), t2);
        end
        adv(2);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
